riscv_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the RISC-V core. Replaces the fixed stall-request OR-tree.
- Tracks every in-flight register writer past ID in an internal slot shift register and derives four things from it: ID→EX operand forwarding selects, load-use stalls, branch flushes, and data-memory wait stalls.
- Supports a configurable pipeline depth and a configurable load-result latency.

---
 rtl/riscv_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl -- pipeline hazard controller for the RISC-V core.
//
// Tracks every in-flight register writer that has left ID in a small shift
// register of DEPTH = NUM_STAGES-2 tracking registers (register 0 = EX,
// register DEPTH-1 = WB). From that state plus the current ID/EX/MEM inputs
// it derives, combinationally (0-cycle latency):
//   - ID->EX operand forwarding selects for rs1 and rs2,
//   - load-use stalls,
//   - branch flushes of IF/ID,
//   - data-memory wait stalls.
//
// Forward-select encoding: 0 = register file, k = result of the writer that
// sits in tracking register k-1 this cycle. When the consumer enters EX on
// the next edge, that writer is exactly k stages ahead of it. An entry in
// EX therefore has select 1, and the WB entry has select DEPTH, hence the
// requirement 2**FWD_W > DEPTH. A non-load is always forwardable. A load is
// forwardable once its select is >= LOAD_READY.
//
// Handshake: mem_ready is a per-cycle accept/return strobe from data memory.
// When it is low, the whole front of the pipe (stages 0..3) holds and the
// tracking registers freeze. A taken branch in that cycle is not acted on
// and must be presented again once mem_ready is high.
//
// Optional feature: define HAZ_PERF_CNT_EN to add the free-running, wrapping
// 32-bit counters stall_cnt_o (memory-wait and load-use cycles) and
// flush_cnt_o (branch flush cycles).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   id_*         instruction currently in ID (valid, sources, destination)
//   ex_br_taken  branch/jump in EX resolved taken
//   mem_ready    data memory accepts/returns this cycle (0 = wait state)
//   stall_o      stall[i]=1 holds pipeline stage i
//   flush_o      bit0 squashes IF, bit1 squashes ID
//   fwd_rs1_o    forward select for rs1 (encoding above)
//   fwd_rs2_o    forward select for rs2
//   stall_cnt_o  (HAZ_PERF_CNT_EN only) stall cycle counter
//   flush_cnt_o  (HAZ_PERF_CNT_EN only) flush cycle counter
module riscv_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  parameter int FWD_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs1_idx,
  input  logic [REG_AW-1:0]     id_rs2_idx,
  input  logic                  id_rs1_re,
  input  logic                  id_rs2_re,
  input  logic [REG_AW-1:0]     id_rd_idx,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  ex_br_taken,
  input  logic                  mem_ready,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [1:0]            flush_o,
  output logic [FWD_W-1:0]      fwd_rs1_o,
  output logic [FWD_W-1:0]      fwd_rs2_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  localparam int DEPTH = NUM_STAGES - 2;

  // Tracking registers: the only state of the core function.
  logic [DEPTH-1:0]  slot_valid;
  logic [DEPTH-1:0]  slot_load;
  logic [REG_AW-1:0] slot_rd [DEPTH];

  // Source lookup results.
  logic             hit1, hit2;
  logic             load1, load2;
  logic [FWD_W-1:0] sel1, sel2;
  logic             rdy1, rdy2;
  logic             load_use;

  // Control decisions.
  logic shift_en;
  logic insert_en;
  logic stall_evt;
  logic flush_evt;

  // Youngest-match search. Scanning from oldest to youngest lets the
  // youngest (lowest-index) hit overwrite older ones.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    sel1  = '0;
    sel2  = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (slot_valid[j] && id_rs1_re && (id_rs1_idx != '0) &&
          (slot_rd[j] == id_rs1_idx)) begin
        hit1  = 1'b1;
        load1 = slot_load[j];
        sel1  = FWD_W'(j + 1);
      end
      if (slot_valid[j] && id_rs2_re && (id_rs2_idx != '0) &&
          (slot_rd[j] == id_rs2_idx)) begin
        hit2  = 1'b1;
        load2 = slot_load[j];
        sel2  = FWD_W'(j + 1);
      end
    end
  end

  // A missing match counts as ready (read from the register file).
  assign rdy1     = !hit1 || !load1 || (int'(sel1) >= LOAD_READY);
  assign rdy2     = !hit2 || !load2 || (int'(sel2) >= LOAD_READY);
  assign load_use = id_valid && (!rdy1 || !rdy2);

  // Priority: memory wait > taken branch > load-use > normal advance.
  always_comb begin
    stall_o   = '0;
    flush_o   = 2'b00;
    fwd_rs1_o = '0;
    fwd_rs2_o = '0;
    shift_en  = 1'b0;
    insert_en = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (rst) begin
      fwd_rs1_o = (hit1 && rdy1) ? sel1 : '0;
      fwd_rs2_o = (hit2 && rdy2) ? sel2 : '0;
      if (!mem_ready) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i < 4) stall_o[i] = 1'b1;
        end
        stall_evt = 1'b1;
      end else if (ex_br_taken) begin
        flush_o   = 2'b11;
        shift_en  = 1'b1;
        flush_evt = 1'b1;
      end else if (load_use) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i < 2) stall_o[i] = 1'b1;
        end
        shift_en  = 1'b1;
        stall_evt = 1'b1;
      end else begin
        shift_en  = 1'b1;
        insert_en = 1'b1;
      end
    end
  end

  // Shift register: bubble on flush/load-use, ID writer otherwise.
  // Writers to x0 are never tracked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int k = 0; k < DEPTH; k++) slot_rd[k] <= '0;
    end else if (shift_en) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end
      slot_valid[0] <= insert_en && id_valid && id_rd_we && (id_rd_idx != '0);
      slot_load[0]  <= insert_en && id_is_load;
      slot_rd[0]    <= id_rd_idx;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_evt) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_evt) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`else
  // Decision strobes only feed the optional counters.
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Testbench for riscv_hazard_ctrl.
// dut  : default parameters (5 stages, LOAD_READY=2), table-driven vectors.
// dut2 : 6 stages, LOAD_READY=3, FWD_W=3, exercises a multi-cycle load-use.
// Both instances share the same input stimulus.
module tb_riscv_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       id_valid, id_rs1_re, id_rs2_re, id_rd_we, id_is_load;
  logic [4:0] id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic       ex_br_taken, mem_ready;
  logic [4:0] stall_o;
  logic [1:0] flush_o;
  logic [1:0] fwd_rs1_o, fwd_rs2_o;
  logic [5:0] stall2_o;
  logic [1:0] flush2_o;
  logic [2:0] fwd2_rs1_o, fwd2_rs2_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o, stall2_cnt_o, flush2_cnt_o;
`endif

  riscv_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
    .stall_o(stall_o), .flush_o(flush_o),
    .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  riscv_hazard_ctrl #(.NUM_STAGES(6), .REG_AW(5), .LOAD_READY(3), .FWD_W(3)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
    .stall_o(stall2_o), .flush_o(flush2_o),
    .fwd_rs1_o(fwd2_rs1_o), .fwd_rs2_o(fwd2_rs2_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(stall2_cnt_o), .flush_cnt_o(flush2_cnt_o)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic       re1;
    logic [4:0] rs2;
    logic       re2;
    logic [4:0] rd;
    logic       we, ld, br, mrdy;
    logic [4:0] stall;
    logic [1:0] flush;
    logic [1:0] f1, f2;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input int vld, rs1, re1, rs2, re2, rd, we, ld,
                              br, mrdy, stall, flush, f1, f2);
    vec_t v;
    v.vld = 1'(vld);  v.rs1 = 5'(rs1); v.re1 = 1'(re1);
    v.rs2 = 5'(rs2);  v.re2 = 1'(re2); v.rd  = 5'(rd);
    v.we  = 1'(we);   v.ld  = 1'(ld);  v.br  = 1'(br);  v.mrdy = 1'(mrdy);
    v.stall = 5'(stall); v.flush = 2'(flush); v.f1 = 2'(f1); v.f2 = 2'(f2);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vld, input logic [4:0] rs1, input logic re1,
                       input logic [4:0] rs2, input logic re2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic br, input logic mrdy);
    id_valid = vld; id_rs1_idx = rs1; id_rs1_re = re1;
    id_rs2_idx = rs2; id_rs2_re = re2; id_rd_idx = rd;
    id_rd_we = we; id_is_load = ld; ex_br_taken = br; mem_ready = mrdy;
  endtask

  // One cycle: drive at the falling edge, sample 2 time units later.
  task automatic step(input logic vld, input logic [4:0] rs1, input logic re1,
                      input logic [4:0] rs2, input logic re2, input logic [4:0] rd,
                      input logic we, input logic ld, input logic br, input logic mrdy);
    @(negedge clk);
    drive(vld, rs1, re1, rs2, re2, rd, we, ld, br, mrdy);
    #2;
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Watchdog: the bench has no open-ended waits, this is only a backstop.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // columns: vld rs1 re1 rs2 re2 rd we ld br mrdy | stall flush f1 f2
    // ALU chain and double match
    tbl[0]  = mk(1,  0,0,  0,0,  5,1,0, 0,1,  0,0, 0,0);
    tbl[1]  = mk(1,  5,1,  0,0,  6,1,0, 0,1,  0,0, 1,0);
    tbl[2]  = mk(1,  6,1,  5,1,  0,0,0, 0,1,  0,0, 1,2);
    tbl[3]  = mk(1,  5,1,  6,1,  0,0,0, 0,1,  0,0, 3,2);
    tbl[4]  = mk(1,  5,1,  6,1,  0,0,0, 0,1,  0,0, 0,3);
    // load-use, one stall cycle at LOAD_READY=2
    tbl[5]  = mk(1,  0,0,  0,0,  7,1,1, 0,1,  0,0, 0,0);
    tbl[6]  = mk(1,  7,1,  0,0,  8,1,0, 0,1,  3,0, 0,0);
    tbl[7]  = mk(1,  7,1,  0,0,  8,1,0, 0,1,  0,0, 2,0);
    tbl[8]  = mk(1,  7,1,  8,1,  0,0,0, 0,1,  0,0, 3,1);
    // branch flush discards the ID writer
    tbl[9]  = mk(1,  0,0,  0,0,  9,1,0, 1,1,  0,3, 0,0);
    tbl[10] = mk(1,  9,1,  8,1,  0,0,0, 0,1,  0,0, 0,3);
    // branch beats load-use
    tbl[11] = mk(1,  0,0,  0,0, 10,1,1, 0,1,  0,0, 0,0);
    tbl[12] = mk(1, 10,1,  0,0,  0,0,0, 1,1,  0,3, 0,0);
    // memory wait, load held in register 1, branch ignored
    tbl[13] = mk(1, 10,1,  0,0,  0,0,0, 0,0, 15,0, 2,0);
    tbl[14] = mk(1, 10,1,  0,0,  0,0,0, 1,0, 15,0, 2,0);
    tbl[15] = mk(1, 10,1,  0,0,  0,0,0, 0,0, 15,0, 2,0);
    tbl[16] = mk(1, 10,1,  0,0,  0,0,0, 0,1,  0,0, 2,0);
    // memory wait beats load-use, then load-use resumes
    tbl[17] = mk(1, 10,1,  0,0, 11,1,1, 0,1,  0,0, 3,0);
    tbl[18] = mk(1, 11,1,  0,0,  0,0,0, 0,0, 15,0, 0,0);
    tbl[19] = mk(1, 11,1,  0,0,  0,0,0, 0,1,  3,0, 0,0);
    tbl[20] = mk(1, 11,1,  0,0,  0,0,0, 0,1,  0,0, 2,0);
    // writer to x0 is never tracked
    tbl[21] = mk(1, 11,1,  0,0,  0,1,0, 0,1,  0,0, 3,0);
    tbl[22] = mk(1,  0,1,  0,1,  0,0,0, 0,1,  0,0, 0,0);
    // read-enable low and id_valid low suppress the stall
    tbl[23] = mk(1,  0,0,  0,0, 12,1,1, 0,1,  0,0, 0,0);
    tbl[24] = mk(1, 12,0, 12,0,  0,0,0, 0,1,  0,0, 0,0);
    tbl[25] = mk(1, 12,1,  0,0, 13,1,1, 0,1,  0,0, 2,0);
    tbl[26] = mk(0, 13,1, 12,1,  0,0,0, 0,1,  0,0, 0,3);

    // ---- reset state (mem_ready low must not stall under reset) ----
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #12;
    check("reset stall", 32'(stall_o), 32'd0);
    check("reset flush", 32'(flush_o), 32'd0);
    check("reset fwd1",  32'(fwd_rs1_o), 32'd0);
    check("reset fwd2",  32'(fwd_rs2_o), 32'd0);
    idle_step();
    rst = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].vld, tbl[i].rs1, tbl[i].re1, tbl[i].rs2, tbl[i].re2,
           tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].br, tbl[i].mrdy);
      check($sformatf("v%0d stall", i), 32'(stall_o),   32'(tbl[i].stall));
      check($sformatf("v%0d flush", i), 32'(flush_o),   32'(tbl[i].flush));
      check($sformatf("v%0d fwd1",  i), 32'(fwd_rs1_o), 32'(tbl[i].f1));
      check($sformatf("v%0d fwd2",  i), 32'(fwd_rs2_o), 32'(tbl[i].f2));
    end

    // ---- reset asserted in the middle of a load-use stall ----
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre-rst stall", 32'(stall_o), 32'd3);
    #1 rst = 1'b0;
    #1;
    check("mid-rst stall", 32'(stall_o), 32'd0);
    check("mid-rst fwd1",  32'(fwd_rs1_o), 32'd0);
    mem_ready = 1'b0;
    #1;
    check("mid-rst memwait stall", 32'(stall_o), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("post-rst stall", 32'(stall_o), 32'd0);
    check("post-rst fwd1",  32'(fwd_rs1_o), 32'd0);

    // ---- LOAD_READY=3 instance: load-use repeats for two cycles ----
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b1);
    check("lr3 issue stall", 32'(stall2_o), 32'd0);
    step(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lr3 stall c1", 32'(stall2_o), 32'd3);
    check("lr3 fwd c1",   32'(fwd2_rs1_o), 32'd0);
    step(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lr3 stall c2", 32'(stall2_o), 32'd3);
    step(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lr3 stall c3", 32'(stall2_o), 32'd0);
    check("lr3 fwd c3",   32'(fwd2_rs1_o), 32'd3);
    check("lr3 mem-wait free flush", 32'(flush2_o), 32'd0);

`ifdef HAZ_PERF_CNT_EN
    // ---- performance counters ----
    do_reset();
    #2;
    check("cnt reset stall", stall_cnt_o, 32'd0);
    check("cnt reset flush", flush_cnt_o, 32'd0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();
    check("stall_cnt", stall_cnt_o, 32'd5);
    check("flush_cnt", flush_cnt_o, 32'd1);
    check("lr3 stall_cnt", stall2_cnt_o, 32'd6);
    check("lr3 flush_cnt", flush2_cnt_o, 32'd1);
`else
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
